// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a START/BUSY/DONE handshake and an iterative
// shift-add multiplier. Single-cycle ops complete one edge after START; a
// multiply runs WIDTH iterations.
// Optional macro SEQ_ALU_MUL_EARLY_EN: the multiply stops as soon as the
// remaining multiplier bits are all zero, with at least one iteration.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             CARRY,
    output logic             OVF,
    output logic             BUSY,
    output logic             DONE
);
    typedef enum logic {IDLE, MUL} state_t;

    localparam logic [WIDTH-1:0] WV  = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] WM1 = WIDTH'(WIDTH - 1);
    localparam logic [CNTW-1:0]  CM1 = CNTW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
    logic                 done_q, done_d;

    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     neg_amt;
    logic [2*WIDTH-1:0]   ror_tmp;
    logic [WIDTH-1:0]     op_res;
    logic                 op_carry, op_ovf;

    logic [2*WIDTH-1:0]   a_shift, acc_sum;
    logic                 mul_last;

    // Single-cycle operation datapath, driven straight from the input operands
    always_comb begin
        sum      = {1'b0, DATA1} + {1'b0, DATA2};
        neg_amt  = -DATA2;
        ror_tmp  = {DATA1, DATA1} >> DATA2[CNTW-1:0];
        op_res   = '0;
        op_carry = 1'b0;
        op_ovf   = 1'b0;
        case (SELECT)
            3'b000: op_res = DATA2;
            3'b001: begin
                op_res   = sum[WIDTH-1:0];
                op_carry = sum[WIDTH];
                op_ovf   = (DATA1[WIDTH-1] == DATA2[WIDTH-1]) &&
                           (sum[WIDTH-1] != DATA1[WIDTH-1]);
            end
            3'b010: op_res = DATA1 & DATA2;
            3'b011: op_res = DATA1 | DATA2;
            3'b101: begin
                // DATA2 is a signed amount: positive shifts left, negative right
                if (!DATA2[WIDTH-1]) begin
                    if (DATA2 < WV) op_res = DATA1 << DATA2;
                end else begin
                    if (neg_amt < WV) op_res = DATA1 >> neg_amt;
                end
            end
            3'b110: begin
                if (DATA2 >= WM1) op_res = {WIDTH{DATA1[WIDTH-1]}};
                else              op_res = $unsigned($signed(DATA1) >>> DATA2);
            end
            3'b111: op_res = ror_tmp[WIDTH-1:0];
            default: op_res = '0;
        endcase
    end

    // One shift-add multiply step and its termination test
    always_comb begin
        a_shift = {{WIDTH{1'b0}}, a_q} << cnt_q;
        acc_sum = acc_q + (b_q[0] ? a_shift : '0);
`ifdef SEQ_ALU_MUL_EARLY_EN
        mul_last = (cnt_q == CM1) || (b_q[WIDTH-1:1] == '0);
`else
        mul_last = (cnt_q == CM1);
`endif
    end

    // Next-state and next-output logic for the IDLE/MUL controller
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    if (SELECT == 3'b100) begin
                        a_d     = DATA1;
                        b_d     = DATA2;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = MUL;
                    end else begin
                        result_d = op_res;
                        zero_d   = (op_res == '0);
                        carry_d  = op_carry;
                        ovf_d    = op_ovf;
                        done_d   = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d = acc_sum;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (mul_last) begin
                    result_d = acc_sum[WIDTH-1:0];
                    zero_d   = (acc_sum[WIDTH-1:0] == '0);
                    carry_d  = |acc_sum[2*WIDTH-1:WIDTH];
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any multiply in flight
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign RESULT = result_q;
    assign ZERO   = zero_q;
    assign CARRY  = carry_q;
    assign OVF    = ovf_q;
    assign BUSY   = (state_q == MUL);
    assign DONE   = done_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed stimulus for seq_alu, checked every
// cycle against an arithmetic reference model of the handshake and ops.
module tb_seq_alu;
    localparam int W    = 8;
    localparam int MOD  = 1 << W;
    localparam int HALF = 1 << (W - 1);

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         carry;
        logic         ovf;
    } out_t;

    logic         CLK, RESET, START, BUSY, DONE, ZERO, CARRY, OVF;
    logic [2:0]   SELECT;
    logic [W-1:0] DATA1, DATA2, RESULT;

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    seq_alu #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
        .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .ZERO(ZERO),
        .CARRY(CARRY), .OVF(OVF), .BUSY(BUSY), .DONE(DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference results from plain integer arithmetic
    function automatic out_t calc(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        out_t o;
        int ia, ib, sa, sb, n, p;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= HALF) ? ia - MOD : ia;
        sb = (ib >= HALF) ? ib - MOD : ib;
        o = '0;
        p = 0;
        case (sel)
            3'd0: p = ib;
            3'd1: begin
                p = ia + ib;
                o.carry = (p >= MOD);
                o.ovf   = (sa + sb > HALF - 1) || (sa + sb < -HALF);
            end
            3'd2: p = ia & ib;
            3'd3: p = ia | ib;
            3'd4: begin
                p = ia * ib;
                o.carry = (p >= MOD);
            end
            3'd5: begin
                n = sb;
                if (n >= W || n <= -W) p = 0;
                else if (n >= 0)       p = ia * (1 << n);
                else                   p = ia / (1 << (-n));
            end
            3'd6: begin
                n = (ib > W - 1) ? W - 1 : ib;
                p = sa >>> n;
            end
            default: begin
                n = ib % W;
                p = (ia >> n) | (ia << (W - n));
            end
        endcase
        o.res  = p[W-1:0];
        o.zero = (o.res == '0);
        return o;
    endfunction

    function automatic int mul_iters(input logic [W-1:0] b);
        int k;
        k = W;
`ifdef SEQ_ALU_MUL_EARLY_EN
        k = 1;
        for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
`endif
        return k;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level model of the handshake
    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    int   m_rem  = 0;
    out_t m_out  = '0;
    out_t m_pend = '0;

    always @(posedge CLK) begin
        if (RESET) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_rem  <= 0;
            m_out  <= '0;
        end else if (!m_busy && START) begin
            if (SELECT == 3'd4) begin
                m_busy <= 1'b1;
                m_rem  <= mul_iters(DATA2);
                m_pend <= calc(SELECT, DATA1, DATA2);
                m_done <= 1'b0;
            end else begin
                m_out  <= calc(SELECT, DATA1, DATA2);
                m_done <= 1'b1;
            end
        end else if (m_busy) begin
            if (m_rem == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_out  <= m_pend;
            end else begin
                m_rem  <= m_rem - 1;
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_done",   32'(DONE),   32'(m_done));
            chk("m_busy",   32'(BUSY),   32'(m_busy));
            chk("m_result", 32'(RESULT), 32'(m_out.res));
            chk("m_zero",   32'(ZERO),   32'(m_out.zero));
            chk("m_carry",  32'(CARRY),  32'(m_out.carry));
            chk("m_ovf",    32'(OVF),    32'(m_out.ovf));
        end
    end

    // Issue one op and wait (bounded) for DONE; lat counts falling edges after the start edge
    task automatic run_op(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        @(posedge CLK); #2;
        START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
        @(posedge CLK); #2;
        START = 1'b0; SELECT = 3'($urandom); DATA1 = W'($urandom); DATA2 = W'($urandom);
        lat = 0;
        while (1) begin
            @(negedge CLK);
            lat++;
            if (DONE) break;
            if (lat >= 40) begin
                chk("done_timeout", 32'(DONE), 32'd1);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t t;
        int   lat;
        logic seen;

        RESET = 1'b1; START = 1'b0; SELECT = '0; DATA1 = '0; DATA2 = '0;
        @(posedge CLK); #2;
        chk_en = 1'b1;
        @(negedge CLK);
        chk("rst_result", 32'(RESULT), 32'h0);
        chk("rst_busy",   32'(BUSY),   32'h0);
        chk("rst_done",   32'(DONE),   32'h0);
        @(posedge CLK); #2;
        RESET = 1'b0;

        // Pin the model to hand-computed values
        t = calc(3'd1, 8'h7F, 8'h01); chk("pin_add_ovf", {t.res, 7'd0, t.ovf, 16'd0}, {8'h80, 7'd0, 1'b1, 16'd0});
        t = calc(3'd4, 8'h0D, 8'h0B); chk("pin_mul",     32'(t.res), 32'h8F);
        t = calc(3'd5, 8'h96, 8'hFE); chk("pin_lsr",     32'(t.res), 32'h25);
        t = calc(3'd6, 8'h96, 8'h03); chk("pin_asr",     32'(t.res), 32'hF2);
        t = calc(3'd7, 8'h96, 8'h0B); chk("pin_ror",     32'(t.res), 32'hD2);

        // Add with flags
        run_op(3'd1, 8'h7F, 8'h01, lat);
        chk("add1_lat", 32'(lat), 32'd1);
        chk("add1_res", 32'(RESULT), 32'h80);
        chk("add1_flags", {29'd0, ZERO, CARRY, OVF}, 32'b001);
        run_op(3'd1, 8'hFF, 8'h01, lat);
        chk("add2_res", 32'(RESULT), 32'h00);
        chk("add2_flags", {29'd0, ZERO, CARRY, OVF}, 32'b110);

        // Multiply
        run_op(3'd4, 8'h0D, 8'h0B, lat);
`ifdef SEQ_ALU_MUL_EARLY_EN
        chk("mul1_lat", 32'(lat), 32'd5);
`else
        chk("mul1_lat", 32'(lat), 32'd9);
`endif
        chk("mul1_res", 32'(RESULT), 32'h8F);
        chk("mul1_carry", 32'(CARRY), 32'd0);
        run_op(3'd4, 8'h20, 8'h10, lat);
        chk("mul2_res", 32'(RESULT), 32'h00);
        chk("mul2_zc", {30'd0, ZERO, CARRY}, 32'b11);

        // Shifts and rotate
        run_op(3'd5, 8'h96, 8'h02, lat); chk("lsl2",  32'(RESULT), 32'h58);
        run_op(3'd5, 8'h96, 8'hFE, lat); chk("lsr2",  32'(RESULT), 32'h25);
        run_op(3'd5, 8'h96, 8'h08, lat); chk("lsl8",  32'(RESULT), 32'h00);
        run_op(3'd6, 8'h96, 8'h03, lat); chk("asr3",  32'(RESULT), 32'hF2);
        run_op(3'd7, 8'h96, 8'h0B, lat); chk("ror11", 32'(RESULT), 32'hD2);

        // Early-termination latency
        run_op(3'd4, 8'h55, 8'h01, lat);
        chk("mul_x1_res", 32'(RESULT), 32'h55);
`ifdef SEQ_ALU_MUL_EARLY_EN
        chk("mul_x1_lat", 32'(lat), 32'd2);
`else
        chk("mul_x1_lat", 32'(lat), 32'd9);
`endif
        run_op(3'd4, 8'h55, 8'h80, lat);
        chk("mul_x80_lat", 32'(lat), 32'd9);

        // START held during a multiply is ignored; START in the DONE cycle is accepted
        @(posedge CLK); #2;
        START = 1'b1; SELECT = 3'd4; DATA1 = 8'h13; DATA2 = 8'h07;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #2;
            SELECT = 3'($urandom_range(0, 3)); DATA1 = W'($urandom); DATA2 = W'($urandom); START = 1'b1;
            @(negedge CLK);
            if (DONE) begin
                seen = 1'b1;
                break;
            end
        end
        chk("hs_done_seen", 32'(seen), 32'd1);
        chk("hs_mul_res", 32'(RESULT), 32'h85);
        SELECT = 3'd2; DATA1 = 8'hF0; DATA2 = 8'h3C; START = 1'b1;
        @(posedge CLK); #2;
        START = 1'b0;
        @(negedge CLK);
        chk("hs_b2b_res", 32'(RESULT), 32'h30);
        chk("hs_b2b_done", 32'(DONE), 32'd1);

        // Reset in the 4th multiply cycle aborts without DONE
        @(posedge CLK); #2;
        START = 1'b1; SELECT = 3'd4; DATA1 = 8'hFF; DATA2 = 8'hFF;
        @(posedge CLK); #2;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RESET = 1'b1;
        @(posedge CLK); #2;
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_mid_res",  32'(RESULT), 32'h0);
        chk("rst_mid_busy", 32'(BUSY), 32'd0);
        chk("rst_mid_done", 32'(DONE), 32'd0);
        run_op(3'd4, 8'hFF, 8'hFF, lat);
        chk("post_rst_mul", {23'd0, CARRY, RESULT}, {23'd0, 1'b1, 8'h01});

        // Randomized traffic, checked by the per-cycle compare
        for (int i = 0; i < 600; i++) begin
            @(posedge CLK); #2;
            RESET  = ($urandom_range(0, 99) == 0);
            START  = ($urandom_range(0, 2) != 0);
            SELECT = 3'($urandom);
            DATA1  = W'($urandom);
            DATA2  = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 12)) : W'($urandom);
        end
        @(posedge CLK); #2;
        RESET = 1'b0; START = 1'b0;
        repeat (12) @(posedge CLK);
        @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU in the CPU datapath.
- Keeps the same 3-bit SELECT operation encoding.
- Adds a START/BUSY/DONE handshake, an iterative shift-add multiplier, a generalised data width, and registered flags (ZERO, CARRY, OVF).
- Sits between the register file read ports and the writeback mux; the control unit stalls on BUSY.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a power of two, at least 4.
- CNTW, $clog2(WIDTH), width of the multiply iteration counter.

Ports:
- CLK  in  1  system clock, rising-edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  request pulse; operands and SELECT are sampled on the edge where START=1 and BUSY=0.
- SELECT  in  3  000 fwd DATA2, 001 add, 010 and, 011 or, 100 mul, 101 lsl/lsr, 110 asr, 111 ror.
- DATA1  in  WIDTH  operand A.
- DATA2  in  WIDTH  operand B, or the shift/rotate amount.
- RESULT  out  WIDTH  registered result; holds its value until the next completion.
- ZERO  out  1  registered; 1 when the new RESULT is 0.
- CARRY  out  1  registered; add: carry-out; mul: upper half of product nonzero; other ops: 0.
- OVF  out  1  registered; add: signed overflow; other ops: 0.
- BUSY  out  1  1 while a multiply is in progress.
- DONE  out  1  one-cycle pulse when RESULT and flags update.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high, on ports CLK and RESET.
- Reset: RESULT=0, ZERO=0, CARRY=0, OVF=0, BUSY=0, DONE=0, state=IDLE, counter=0.
- RESET has priority over everything. RESET during MUL aborts the multiply; no DONE is produced.
- FSM states: IDLE and MUL.
  - IDLE + START with SELECT != 100: compute at edge E0; RESULT, flags and DONE=1 are visible the cycle after E0 (latency 1). Stay in IDLE.
  - IDLE + START with SELECT = 100: latch A=DATA1, B=DATA2, clear the 2*WIDTH-bit accumulator. Go to MUL with BUSY=1.
  - MUL: one iteration per edge, E1..E_WIDTH. If B[0]=1, add A (shifted by the counter) into the accumulator; then shift B right and increment the counter.
  - At edge E_WIDTH: RESULT = product[WIDTH-1:0], CARRY = |product[2W-1:W], DONE=1, BUSY=0, state returns to IDLE.
- START while BUSY=1 is ignored; no queueing.
- START in the DONE cycle is accepted, giving back-to-back operation.
- DONE is 0 in every cycle without a completion.
- Operands are captured at START. Later changes to DATA1/DATA2/SELECT do not affect the operation in flight.
- Arithmetic (all modulo 2^WIDTH):
  - add: CARRY = bit WIDTH of the (WIDTH+1)-bit sum; OVF = (A[msb]==B[msb]) && (S[msb]!=A[msb]).
  - fwd: RESULT = DATA2.
- Shift op 101: DATA2 is a signed two's-complement amount n.
  - n>=0: logical left by n.
  - n<0: logical right by |n|.
  - |n| >= WIDTH: RESULT = 0.
- asr op 110: DATA2 is unsigned. Shift right with sign fill; DATA2 >= WIDTH-1 gives all bits = DATA1[msb].
- ror op 111: rotate right by DATA2 mod WIDTH.
- ZERO is evaluated on the new RESULT for every op, not on the adder output.

Optional Feature:
- Macro: SEQ_ALU_MUL_EARLY_EN.
- Defined: multiply terminates at the first edge where the remaining shifted B is 0, with at least one iteration. DONE then follows that edge; multiplier 1 or 0 completes after E1. Result is identical to the full-length multiply.
- Undefined: multiply always takes exactly WIDTH iterations, DONE after E_WIDTH.

Test Plan (WIDTH=8):
- Add with flags: START, SELECT=001, DATA1=0x7F, DATA2=0x01 → next cycle RESULT=0x80, OVF=1, CARRY=0, ZERO=0, DONE=1 for one cycle. Then 0xFF+0x01 → RESULT=0x00, CARRY=1, ZERO=1.
- Multiply: SELECT=100, 0x0D×0x0B → BUSY=1 for 8 cycles, then RESULT=0x8F, CARRY=0, DONE pulse. 0x20×0x10 → RESULT=0x00, CARRY=1, ZERO=1.
- Shifts: SELECT=101 0x96 by 0x02 → 0x58; 0x96 by 0xFE → 0x25; 0x96 by 0x08 → 0x00. SELECT=110 0x96 by 0x03 → 0xF2. SELECT=111 0x96 by 0x0B → 0xD2.
- Handshake: START asserted each cycle during a multiply with other SELECT values → ignored, single DONE. START in the DONE cycle (SELECT=010, 0xF0&0x3C) → RESULT=0x30 the next cycle.
- Reset mid-operation: RESET at the 4th MUL cycle → next cycle all outputs 0, BUSY=0, no DONE; a new multiply completes normally.
- Early termination with SEQ_ALU_MUL_EARLY_EN defined: 0x55×0x01 → DONE after E1, RESULT=0x55. 0x55×0x80 → DONE after E8.
